// File: rtl/v810_bus_target.sv
// v810_bus_target: multi-region external-bus target for the V810 MAU bus.
// The top address bits select one of NREG regions. Each region emulates a
// 32/16/8-bit device with its own wait-state count, reports bus sizing on
// SZRQn, and maps the access onto a 32-bit asynchronous-read backing RAM.
//
// Bus handshake: an access starts when the target is idle and samples
// MRQn=0 and DAn=0 on a CE-qualified clock edge. The target then holds READYn
// low for exactly one CE cycle once the wait states have elapsed. D_I and
// SZRQn are meaningful only while READYn=0. If SZRQn=0 with READYn=0, only
// part of the requested lanes was served. The controller then re-drives BEn
// with the remaining lanes, and that starts a fresh, independent access. MRQn
// going high during the wait phase aborts the access without a READYn pulse.
module v810_bus_target #(
  parameter int NREG = 4,
  parameter int AW   = 10,
  parameter int WSW  = 4
) (
  input  logic                CLK,
  input  logic                RES,
  input  logic                CE,
  input  logic [31:0]         A,
  input  logic [3:0]          BEn,
  input  logic                DAn,
  input  logic                MRQn,
  input  logic                RW,
  input  logic [31:0]         D_O,
  output logic [31:0]         D_I,
  output logic                READYn,
  output logic                SZRQn,
  input  logic [NREG*WSW-1:0] CFG_WS,
  input  logic [NREG*2-1:0]   CFG_DW,
  output logic [AW-1:0]       MEM_A,
  output logic                MEM_CEn,
  output logic                MEM_WEn,
  output logic [3:0]          MEM_BEn,
  output logic [31:0]         MEM_WD,
  input  logic [31:0]         MEM_RD,
  output logic [1:0]          dbg_state
);

  // Region index width; a single-region build still needs a 1-bit vector,
  // but the index is then forced to zero.
  localparam int RBW = (NREG > 1) ? $clog2(NREG) : 1;

  // FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  // Data-width codes; code 3 is reserved and behaves like 32-bit.
  localparam logic [1:0] DW_32 = 2'd0;
  localparam logic [1:0] DW_16 = 2'd1;
  localparam logic [1:0] DW_8  = 2'd2;

  // Registered access context.
  logic [1:0]     state_q;
  logic [WSW-1:0] cnt_q;
  logic [AW-1:0]  word_q;
  logic           rw_q;
  logic [3:0]     serve_q;
  logic [3:0]     rem_q;

  // Start-of-access decode.
  logic [RBW-1:0] region_idx;
  logic [WSW-1:0] ws_sel;
  logic [1:0]     dw_sel;
  logic [3:0]     en;
  logic [3:0]     serve_d;
  logic [3:0]     rem_d;
  logic           start;

  // Output helpers.
  logic           in_ready;
  logic           ram_sel;
  logic [31:0]    lane_mask;

  // Address bits outside region/word fields and the reserved DW code are
  // intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^A;

  // Decode the region, fetch its configuration, and build the served and
  // remaining lane masks for an access that could start this cycle.
  always_comb begin
    region_idx = '0;
    if (NREG > 1) begin
      region_idx = A[31 -: RBW];
    end
    ws_sel = CFG_WS[int'(region_idx)*WSW +: WSW];
    dw_sel = CFG_DW[int'(region_idx)*2 +: 2];
    en     = ~BEn;

    serve_d = en;
    case (dw_sel)
      DW_16: begin
        // A 16-bit device serves the low half first if any low lane is asked for.
        if (en[1:0] != 2'b00) begin
          serve_d = en & 4'b0011;
        end else begin
          serve_d = en & 4'b1100;
        end
      end
      DW_8: begin
        // Isolate the lowest requested lane.
        serve_d = en & (~en + 4'd1);
      end
      default: begin
        serve_d = en;
      end
    endcase
    rem_d = en & ~serve_d;

    start = (state_q == ST_IDLE) && !MRQn && !DAn;
  end

  // Access FSM: idle -> optional wait countdown -> one ready cycle.
  // Everything advances only on CE; reset wins over CE.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      rw_q    <= 1'b1;
      serve_q <= 4'h0;
      rem_q   <= 4'h0;
    end else if (CE) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            word_q  <= A[AW+1:2];
            rw_q    <= RW;
            serve_q <= serve_d;
            rem_q   <= rem_d;
            if (ws_sel == '0) begin
              state_q <= ST_READY;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= ws_sel - 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (MRQn) begin
            // Controller withdrew the request: drop it silently.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= ST_READY;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_READY: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus and RAM outputs are decoded from the registered state. The RAM is
  // only selected on a CE cycle, so a frozen ready cycle cannot commit a
  // write twice, and an access with no enabled lanes never touches the RAM.
  always_comb begin
    in_ready  = (state_q == ST_READY);
    ram_sel   = in_ready && CE && (serve_q != 4'h0);
    lane_mask = {{8{serve_q[3]}}, {8{serve_q[2]}}, {8{serve_q[1]}}, {8{serve_q[0]}}};

    READYn  = ~in_ready;
    SZRQn   = ~(in_ready && (rem_q != 4'h0));
    MEM_CEn = ~ram_sel;
    MEM_WEn = in_ready ? rw_q : 1'b1;
    MEM_BEn = in_ready ? ~serve_q : 4'hF;
    MEM_A   = word_q;
    MEM_WD  = D_O;

    D_I = 32'h0;
    if (ram_sel && rw_q) begin
      D_I = MEM_RD & lane_mask;
    end

    dbg_state = state_q;
  end

endmodule

// File: tb/tb_v810_bus_target.sv
// tb_v810_bus_target: directed checks of region decode, bus sizing, wait
// states, clock enable, abort and reset behaviour of v810_bus_target.
module tb_v810_bus_target;

  localparam int NREG = 4;
  localparam int AW   = 10;
  localparam int WSW  = 4;

  // Clock / reset block
  logic CLK = 1'b0;
  logic RES;
  always #5 CLK = ~CLK;

  logic                CE;
  logic [31:0]         A;
  logic [3:0]          BEn;
  logic                DAn;
  logic                MRQn;
  logic                RW;
  logic [31:0]         D_O;
  logic [31:0]         D_I;
  logic                READYn;
  logic                SZRQn;
  logic [NREG*WSW-1:0] CFG_WS;
  logic [NREG*2-1:0]   CFG_DW;
  logic [AW-1:0]       MEM_A;
  logic                MEM_CEn;
  logic                MEM_WEn;
  logic [3:0]          MEM_BEn;
  logic [31:0]         MEM_WD;
  logic [31:0]         MEM_RD;
  logic [1:0]          dbg_state;

  v810_bus_target #(.NREG(NREG), .AW(AW), .WSW(WSW)) dut (
    .CLK(CLK), .RES(RES), .CE(CE), .A(A), .BEn(BEn), .DAn(DAn), .MRQn(MRQn),
    .RW(RW), .D_O(D_O), .D_I(D_I), .READYn(READYn), .SZRQn(SZRQn),
    .CFG_WS(CFG_WS), .CFG_DW(CFG_DW), .MEM_A(MEM_A), .MEM_CEn(MEM_CEn),
    .MEM_WEn(MEM_WEn), .MEM_BEn(MEM_BEn), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD),
    .dbg_state(dbg_state)
  );

  // Backing RAM model: asynchronous read, byte-lane write on the clock edge.
  logic [31:0] mem [0:(1<<AW)-1];
  logic        pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign MEM_RD = mem[MEM_A];

  always @(posedge CLK) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (!MEM_CEn && !MEM_WEn) begin
      for (int l = 0; l < 4; l++) begin
        if (!MEM_BEn[l]) mem[MEM_A][l*8 +: 8] <= MEM_WD[l*8 +: 8];
      end
    end
  end

  // Scoreboard counters
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic preload(input logic [AW-1:0] addr, input logic [31:0] data);
    pre_addr = addr;
    pre_data = data;
    pre_we   = 1'b1;
    @(posedge CLK);
    #1 pre_we = 1'b0;
  endtask

  // Runs one access with CE held high. Entered and left 1 time unit after a
  // rising edge. Returns the number of edges until READYn went low and the
  // outputs sampled during the ready cycle.
  task automatic access(input logic [31:0] addr, input logic [3:0] be,
                        input logic rw, input logic [31:0] wd,
                        output int lat, output logic [31:0] di,
                        output logic sz, output logic [3:0] ben,
                        output logic cen, output logic wen);
    logic got;
    A = addr; BEn = be; RW = rw; D_O = wd; MRQn = 1'b0; DAn = 1'b0; CE = 1'b1;
    lat = 0;
    got = 1'b0;
    di = 'x; sz = 'x; ben = 'x; cen = 'x; wen = 'x;
    while (!got && lat < 40) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (READYn === 1'b0) begin
        got = 1'b1;
        di  = D_I;
        sz  = SZRQn;
        ben = MEM_BEn;
        cen = MEM_CEn;
        wen = MEM_WEn;
      end
    end
    if (!got) chk("access_timeout", 32'(got), 32'd1);
    DAn = 1'b1; MRQn = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  int          lat;
  logic [31:0] di;
  logic        sz;
  logic [3:0]  ben;
  logic        cen;
  logic        wen;
  int          ce_hi;
  int          n;
  int          strobe_bad;
  int          ready_seen;
  logic        got;

  initial begin
    // Region config: r0 32-bit/0ws, r1 16-bit/1ws, r2 8-bit/0ws, r3 32-bit/15ws.
    CFG_WS = 16'hF010;
    CFG_DW = 8'h24;
    RES = 1'b1; CE = 1'b0; A = '0; BEn = 4'hF; DAn = 1'b1; MRQn = 1'b1;
    RW = 1'b1; D_O = '0;

    @(posedge CLK);
    #1;
    preload(10'd1, 32'h0000_0000);
    preload(10'd2, 32'h1122_3344);
    preload(10'd3, 32'h0102_0304);
    preload(10'd4, 32'hDEAD_BEEF);
    preload(10'd5, 32'h5555_5555);

    // Reset state (CE low while reset is held)
    @(negedge CLK);
    chk("rst_readyn", 32'(READYn), 32'd1);
    chk("rst_szrqn", 32'(SZRQn), 32'd1);
    chk("rst_di", D_I, 32'h0);
    chk("rst_mem_cen", 32'(MEM_CEn), 32'd1);
    chk("rst_mem_wen", 32'(MEM_WEn), 32'd1);
    chk("rst_mem_ben", 32'(MEM_BEn), 32'hF);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(posedge CLK);
    #1 RES = 1'b0; CE = 1'b1;

    // Region 0, 32-bit, no wait states: full-word read
    access(32'h0000_0008, 4'h0, 1'b1, 32'h0, lat, di, sz, ben, cen, wen);
    chk("r0_lat", 32'(lat), 32'd1);
    chk("r0_szrqn", 32'(sz), 32'd1);
    chk("r0_di", di, 32'h1122_3344);
    chk("r0_mem_ben", 32'(ben), 32'h0);
    chk("r0_mem_cen", 32'(cen), 32'd0);

    // Region 1, 16-bit, 1 wait state: word write split into two halves
    access(32'h4000_0004, 4'h0, 1'b0, 32'hAABB_CCDD, lat, di, sz, ben, cen, wen);
    chk("r1a_lat", 32'(lat), 32'd2);
    chk("r1a_szrqn", 32'(sz), 32'd0);
    chk("r1a_mem_ben", 32'(ben), 32'hC);
    chk("r1a_mem_wen", 32'(wen), 32'd0);
    chk("r1a_ram", mem[1], 32'h0000_CCDD);
    access(32'h4000_0004, 4'h3, 1'b0, 32'hAABB_CCDD, lat, di, sz, ben, cen, wen);
    chk("r1b_lat", 32'(lat), 32'd2);
    chk("r1b_szrqn", 32'(sz), 32'd1);
    chk("r1b_mem_ben", 32'(ben), 32'h3);
    chk("r1b_ram", mem[1], 32'hAABB_CCDD);

    // Region 2, 8-bit: four byte sub-cycles, lowest lane first
    access(32'h8000_000C, 4'h0, 1'b1, 32'h0, lat, di, sz, ben, cen, wen);
    chk("r2_b0_lat", 32'(lat), 32'd1);
    chk("r2_b0_szrqn", 32'(sz), 32'd0);
    chk("r2_b0_ben", 32'(ben), 32'hE);
    chk("r2_b0_di", di, 32'h0000_0004);
    access(32'h8000_000C, 4'h1, 1'b1, 32'h0, lat, di, sz, ben, cen, wen);
    chk("r2_b1_szrqn", 32'(sz), 32'd0);
    chk("r2_b1_di", di, 32'h0000_0300);
    access(32'h8000_000C, 4'h3, 1'b1, 32'h0, lat, di, sz, ben, cen, wen);
    chk("r2_b2_szrqn", 32'(sz), 32'd0);
    chk("r2_b2_di", di, 32'h0002_0000);
    access(32'h8000_000C, 4'h7, 1'b1, 32'h0, lat, di, sz, ben, cen, wen);
    chk("r2_b3_szrqn", 32'(sz), 32'd1);
    chk("r2_b3_ben", 32'(ben), 32'h7);
    chk("r2_b3_di", di, 32'h0100_0000);

    // No enabled lanes: completes, but never selects the RAM
    access(32'h0000_0008, 4'hF, 1'b1, 32'h0, lat, di, sz, ben, cen, wen);
    chk("en0_lat", 32'(lat), 32'd1);
    chk("en0_szrqn", 32'(sz), 32'd1);
    chk("en0_mem_cen", 32'(cen), 32'd1);
    chk("en0_di", di, 32'h0);

    // Region 3, 15 wait states, CE toggling every cycle
    A = 32'hC000_0010; BEn = 4'h0; RW = 1'b1; MRQn = 1'b0; DAn = 1'b0; CE = 1'b1;
    ce_hi = 0; n = 0; strobe_bad = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(posedge CLK);
      if (CE) ce_hi++;
      n++;
      #1 CE = ~CE;
      @(negedge CLK);
      if (!CE && MEM_CEn !== 1'b1) strobe_bad++;
      if (READYn === 1'b0) got = 1'b1;
    end
    chk("ws15_ready_seen", 32'(got), 32'd1);
    chk("ws15_ce_cycles", 32'(ce_hi), 32'd16);
    chk("ws15_no_strobe_ce0", 32'(strobe_bad), 32'd0);
    chk("ws15_hold_readyn", 32'(READYn), 32'd0);
    chk("ws15_hold_mem_cen", 32'(MEM_CEn), 32'd1);
    CE = 1'b1;
    #1;
    chk("ws15_mem_cen", 32'(MEM_CEn), 32'd0);
    chk("ws15_di", D_I, 32'hDEAD_BEEF);
    DAn = 1'b1; MRQn = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("ws15_after_readyn", 32'(READYn), 32'd1);
    @(posedge CLK);
    #1;

    // Reset asserted during the wait phase of a write
    A = 32'hC000_0014; BEn = 4'h0; RW = 1'b0; D_O = 32'h1234_5678;
    MRQn = 1'b0; DAn = 1'b0; CE = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1 RES = 1'b1;
    @(negedge CLK);
    chk("rstw_state_wait", 32'(dbg_state), 32'd1);
    @(posedge CLK);
    #1 RES = 1'b0; DAn = 1'b1; MRQn = 1'b1;
    @(negedge CLK);
    chk("rstw_readyn", 32'(READYn), 32'd1);
    chk("rstw_szrqn", 32'(SZRQn), 32'd1);
    chk("rstw_di", D_I, 32'h0);
    chk("rstw_mem_cen", 32'(MEM_CEn), 32'd1);
    chk("rstw_mem_wen", 32'(MEM_WEn), 32'd1);
    chk("rstw_mem_ben", 32'(MEM_BEn), 32'hF);
    chk("rstw_state", 32'(dbg_state), 32'd0);
    ready_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (READYn === 1'b0) ready_seen++;
    end
    chk("rstw_no_ready", 32'(ready_seen), 32'd0);
    chk("rstw_ram", mem[5], 32'h5555_5555);
    @(posedge CLK);
    #1;

    // Abort: MRQn withdrawn during the wait phase
    A = 32'hC000_0010; BEn = 4'h0; RW = 1'b1; MRQn = 1'b0; DAn = 1'b0; CE = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(posedge CLK);
    #1 MRQn = 1'b1; DAn = 1'b1;
    ready_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (READYn === 1'b0) ready_seen++;
    end
    chk("abort_no_ready", 32'(ready_seen), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'd0);
    @(posedge CLK);
    #1;
    access(32'h0000_0008, 4'h0, 1'b1, 32'h0, lat, di, sz, ben, cen, wen);
    chk("post_abort_lat", 32'(lat), 32'd1);
    chk("post_abort_di", di, 32'h1122_3344);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/v810_bus_target.md
Name: v810_bus_target

Overview:
Parametrised external-bus target model for the V810 MAU bus. It decodes the address into NREG regions. Each region has its own runtime-selectable emulated data width (32/16/8) and wait-state count. The block drives READYn/SZRQn bus sizing and front-ends a 32-bit backing RAM. It supersedes the single-region bus resizer for multi-device benches: ROM, RAM and I/O on one bus with different timings.

Parameters:
NREG, 4, number of address regions; power of 2, ≥1; RB = $clog2(NREG), region = A[31:32-RB] (region 0 when NREG=1)
AW, 10, backing-RAM word-address width; MEM_A = A[AW+1:2]
WSW, 4, width of each region's wait-state field

Ports:
CLK  in  1  clock
RES  in  1  synchronous reset, active-high
CE  in  1  clock enable; state advances only when CE=1
A  in  32  bus address
BEn  in  4  byte enables, active-low
DAn  in  1  data strobe, active-low
MRQn  in  1  memory request, active-low
RW  in  1  1=read, 0=write
D_O  in  32  write data from controller
D_I  out  32  read data to controller
READYn  out  1  cycle complete, active-low
SZRQn  out  1  bus-size request, active-low, valid only with READYn=0
CFG_WS  in  NREG*WSW  per-region wait states; region r at [r*WSW +: WSW]
CFG_DW  in  NREG*2  per-region width; 0=32, 1=16, 2=8, 3=reserved (treated as 32)
MEM_A  out  AW  RAM word address
MEM_CEn  out  1  RAM select, active-low
MEM_WEn  out  1  RAM write, active-low
MEM_BEn  out  4  RAM lane enables, active-low
MEM_WD  out  32  RAM write data (=D_O)
MEM_RD  in  32  RAM read data; asynchronous, valid while MEM_CEn=0

Behaviour:
- Reset (RES=1 at CLK edge, regardless of CE):
  - state=IDLE.
  - READYn=1, SZRQn=1, D_I=0, MEM_CEn=1, MEM_WEn=1, MEM_BEn=4'hF.
- States: IDLE, WAIT, READY.
- IDLE → start when CE=1 and MRQn=0 and DAn=0.
  - Latch A, BEn, RW, region r, WS=CFG_WS[r], DW=CFG_DW[r].
  - Compute served lane mask S (active-high) from en=~BEn:
    - DW=32: S=en.
    - DW=16: S=en&4'b0011 if en[1:0]≠0, else en&4'b1100.
    - DW=8: S=lowest set bit of en.
  - Remaining mask R = en & ~S.
  - Next state: WS=0 → READY; else WAIT with counter=WS-1.
- WAIT: each CE cycle, if counter=0 → READY, else counter-1.
- READY (exactly one CE cycle), then → IDLE:
  - READYn=0.
  - SZRQn=0 iff R≠0.
  - MEM_CEn=0, MEM_BEn=~S, MEM_WEn=RW.
  - Read: D_I lanes in S = MEM_RD lanes; other lanes = 0.
  - Write commits at the closing CLK edge.
- Latency: READYn low in the (WS+1)th CE cycle after the start edge. Minimum access = 2 CE cycles (IDLE sample + READY).
- Sizing continuation: the controller re-drives BEn for R. The next IDLE cycle with DAn=0 starts a new independent access. No state is kept between sizing sub-cycles.
- Outside READY: READYn=1, SZRQn=1, MEM_CEn=1, MEM_WEn=1, MEM_BEn=4'hF, D_I=0.
- CE=0:
  - State and counter freeze.
  - MEM_CEn forced 1, so no write commits.
  - READYn/SZRQn hold their values.
- Abort: MRQn=1 sampled in WAIT → IDLE. No READYn pulse, no RAM access.
- en=0 (BEn=4'hF): access still completes with READYn=0 after WS. SZRQn=1, MEM_CEn stays 1, D_I=0.
- Counter width WSW. WS=2^WSW-1 is legal with no wrap. Config changes during an access have no effect until the next start.
- Reset mid-access: immediate IDLE, no READYn pulse, no write.

Test Plan:
- Region 0 DW=32 WS=0; read A=0x00000008, BEn=0, RAM word 2=0x11223344 → READYn low on 2nd cycle, SZRQn=1, D_I=0x11223344.
- Region 1 (A=0x40000004) DW=16 WS=1; write D_O=0xAABBCCDD, BEn=0:
  - 1st READYn (cycle 3): SZRQn=0, MEM_BEn=4'b1100.
  - Controller reissues BEn=4'b0011: SZRQn=1.
  - RAM word 1 = 0xAABBCCDD.
- Region 2 DW=8 WS=0; read BEn=4'b0000, RAM=0x01020304 → four sub-cycles with S=0001,0010,0100,1000. SZRQn=0 on the first three, D_I lanes 0x04, 0x0300, 0x020000, 0x01000000.
- WS=15 read with CE toggling 1/0 every cycle → READYn low after exactly 16 CE-high cycles. No RAM strobe while CE=0.
- Assert RES in WAIT of a write → READYn never pulses. RAM unchanged. Outputs at reset values the cycle after.
- MRQn deasserted mid-WAIT → return to IDLE without READYn. A following read completes normally.
